apx_float_addsub: RTL and testbench
===================================

APX_FLOAT_ADDSUB -- requirements
Module: apx_float_addsub

Interface
REQ-001 The block SHALL have parameter TRUNC_MAX, default 3, the largest number of significand LSBs that approximation may clear (legal 0..8).
REQ-002 The block SHALL have parameter LVL_W, default 4, the width of apx_level.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port input_a, input, 32 bits: IEEE-754 single-precision operand A.
REQ-006 Port input_a_stb, input, 1 bit: A valid.
REQ-007 Port input_a_ack, output, 1 bit: block ready for A.
REQ-008 Port input_b, input, 32 bits: IEEE-754 single-precision operand B.
REQ-009 Port input_b_stb, input, 1 bit: B valid.
REQ-010 Port input_b_ack, output, 1 bit: block ready for B.
REQ-011 Port op, input, 1 bit: 0 = A+B, 1 = A-B; sampled with the B transfer.
REQ-012 Port apx_level, input, LVL_W bits: truncation depth K; sampled with the B transfer.
REQ-013 Port output_z, output, 32 bits: IEEE-754 result.
REQ-014 Port output_z_stb, output, 1 bit: result valid.
REQ-015 Port output_z_ack, input, 1 bit: consumer has taken the result.

Function
REQ-016 A transfer SHALL occur on a rising edge where stb and ack are both 1; ack SHALL deassert on the following cycle.
REQ-017 The FSM SHALL use states GET_A -> GET_B -> UNPACK -> SPECIAL -> ALIGN -> ADD -> NORM -> ROUND -> PACK -> PUT_Z -> GET_A.
- input_a_ack = 1 only in GET_A.
- input_b_ack = 1 only in GET_B.
- output_z_stb = 1 only in PUT_Z.
REQ-018 op = 1 SHALL invert the sign of B before any other processing.
REQ-019 K SHALL equal min(apx_level, TRUNC_MAX).
- At UNPACK, the low K bits of each 24-bit significand (hidden bit included) SHALL be forced to 0.
REQ-020 Denormal inputs (exp = 0, mantissa != 0) SHALL be flushed to signed zero at UNPACK.
REQ-021 ALIGN SHALL right-shift the smaller-exponent 27-bit significand (24 + guard, round, sticky) by one bit per cycle, ORing shifted-out bits into sticky.
- An exponent difference > 26 SHALL saturate: the significand collapses to sticky only, in one cycle.
REQ-022 Rounding SHALL depend on K.
- K = 0: round-to-nearest-even; results bit-identical to the accurate adder.
- K > 0: truncate toward zero; guard, round and sticky are discarded.
REQ-023 Special cases SHALL be resolved in SPECIAL, skipping ALIGN through ROUND.
- Any NaN -> 0x7FC00000.
- inf + (-inf) -> 0x7FC00000.
- inf + finite -> that inf.
- Both zero -> -0 only if both are -0, else +0.
REQ-024 An exact-zero difference of finite operands SHALL give +0.
- Exponent overflow -> signed infinity.
- Result below the minimum normal -> signed zero.
REQ-025 output_z SHALL be held stable while output_z_stb = 1, for any number of cycles, until output_z_ack = 1 on an edge.
- The FSM then returns to GET_A.
REQ-026 Latency from the B transfer to output_z_stb rising SHALL be at most 36 cycles.
- Special cases SHALL take at most 5 cycles.
REQ-027 input_a_stb, input_b_stb, op and apx_level SHALL be ignored outside their acceptance states.

Reset
REQ-028 While rst = 0, the block SHALL hold:
- state = GET_A;
- input_a_ack = 0, input_b_ack = 0, output_z_stb = 0;
- output_z = 0x00000000.
REQ-029 input_a_ack SHALL assert on the first rising edge after rst returns to 1.
REQ-030 Reset asserted mid-operation SHALL abort the operation immediately and asynchronously; the partial result is never presented.

Verification
REQ-031 Add, exact: 0x3FC00000 + 0x40100000, op = 0, K = 0 -> 0x40700000.
REQ-032 Subtract, exact: 0x40800000 - 0x3F800000, op = 1, K = 0 -> 0x40400000.
REQ-033 Approximation: 0x3F800007 + 0x3F800000.
- K = 0 -> 0x40000004.
- K = 3 -> 0x40000000.
- apx_level = 15 is clamped to K = 3 -> 0x40000000.
REQ-034 Special values:
- 0x7F800000 + 0xFF800000 -> 0x7FC00000.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
- 0x80000000 + 0x80000000 -> 0x80000000.
REQ-035 Back-pressure: hold output_z_ack = 0 for 20 cycles.
- output_z_stb stays 1, output_z is unchanged and input_a_ack stays 0.
- After output_z_ack pulses, input_a_ack = 1 on the next edge.
REQ-036 Reset mid-operation: drive rst = 0 while in ALIGN.
- All stb and ack outputs go to 0 immediately.
- After release, input_a_ack = 1 on the first edge.
- A following 0x3FC00000 + 0x40100000 gives 0x40700000.

Source files
------------

// File: rtl/apx_float_addsub.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor with optional
// significand truncation: apx_level > 0 trades accuracy for truncating rounding.
module apx_float_addsub #(
  parameter int TRUNC_MAX = 3,
  parameter int LVL_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [31:0]      input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  input  logic             op,
  input  logic [LVL_W-1:0] apx_level,
  output logic [31:0]      output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, PUT_Z
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
  logic [3:0]         k_q, k_d;
  logic [26:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic [27:0]        sum_q, sum_d;
  logic               z_s_q, z_s_d, zero_q, zero_d;
  logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

  logic [23:0]        mask;
  logic [4:0]         lz;
  logic               lz_found;
  logic signed [9:0]  e_diff;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  function automatic logic signed [9:0] unbias(input logic [7:0] e);
    return (e == 8'd0) ? -10'sd126 : ($signed({2'b00, e}) - 10'sd127);
  endfunction

  function automatic logic [23:0] signif(input logic [31:0] f);
    return (f[30:23] != 8'd0) ? {1'b1, f[22:0]} : 24'd0;
  endfunction

  assign mask   = ~((24'd1 << k_q) - 24'd1);
  assign e_diff = a_e_q - b_e_q;
  assign a_nan  = (&a_q[30:23]) && (|a_q[22:0]);
  assign b_nan  = (&b_q[30:23]) && (|b_q[22:0]);
  assign a_inf  = (&a_q[30:23]) && !(|a_q[22:0]);
  assign b_inf  = (&b_q[30:23]) && !(|b_q[22:0]);
  assign a_zero = (a_q[30:23] == 8'd0);
  assign b_zero = (b_q[30:23] == 8'd0);

  // Leading-zero count of the unsigned sum so normalisation finishes in one cycle.
  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && sum_q[i]) begin
        lz       = 5'(26 - i);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    k_d     = k_q;
    a_m_d   = a_m_q;
    b_m_d   = b_m_q;
    z_m_d   = z_m_q;
    a_e_d   = a_e_q;
    b_e_d   = b_e_q;
    z_e_d   = z_e_q;
    sum_d   = sum_q;
    z_s_d   = z_s_q;
    zero_d  = zero_q;

    case (state_q)
      GET_A: begin
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (b_ack_q && input_b_stb) begin
          b_d     = {input_b[31] ^ op, input_b[30:0]};
          k_d     = (int'(apx_level) > TRUNC_MAX) ? 4'(TRUNC_MAX) : 4'(apx_level);
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        a_m_d   = {signif(a_q) & mask, 3'b000};
        b_m_d   = {signif(b_q) & mask, 3'b000};
        a_e_d   = unbias(a_q[30:23]);
        b_e_d   = unbias(b_q[30:23]);
        state_d = SPECIAL;
      end
      SPECIAL: begin
        state_d = PUT_Z;
        if (a_nan || b_nan) begin
          z_d = 32'h7FC00000;
        end else if (a_inf) begin
          z_d = (b_inf && (a_q[31] != b_q[31])) ? 32'h7FC00000 : {a_q[31], 8'hFF, 23'd0};
        end else if (b_inf) begin
          z_d = {b_q[31], 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
          z_d = {a_q[31] & b_q[31], 31'd0};
        end else begin
          state_d = ALIGN;
        end
      end
      // One bit of shift per cycle; gaps wider than the 27-bit field collapse to sticky.
      ALIGN: begin
        if (e_diff > 10'sd26) begin
          b_m_d = {26'd0, |b_m_q};
          b_e_d = a_e_q;
        end else if (e_diff > 10'sd0) begin
          b_m_d = {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
          b_e_d = b_e_q + 10'sd1;
        end else if (e_diff < -10'sd26) begin
          a_m_d = {26'd0, |a_m_q};
          a_e_d = b_e_q;
        end else if (e_diff < 10'sd0) begin
          a_m_d = {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
          a_e_d = a_e_q + 10'sd1;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        z_e_d = a_e_q;
        if (a_q[31] == b_q[31]) begin
          sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
          z_s_d = a_q[31];
        end else if (a_m_q >= b_m_q) begin
          sum_d = {1'b0, a_m_q} - {1'b0, b_m_q};
          z_s_d = a_q[31];
        end else begin
          sum_d = {1'b0, b_m_q} - {1'b0, a_m_q};
          z_s_d = b_q[31];
        end
        state_d = NORM;
      end
      NORM: begin
        zero_d = (sum_q == 28'd0);
        if (sum_q[27]) begin
          z_m_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
          z_e_d = z_e_q + 10'sd1;
        end else begin
          z_m_d = sum_q[26:0] << lz;
          z_e_d = z_e_q - $signed({5'd0, lz});
        end
        state_d = ROUND;
      end
      // Exact mode rounds to nearest-even; any truncation depth simply drops G/R/S.
      ROUND: begin
        if ((k_q == 4'd0) && z_m_q[2] && (z_m_q[1] | z_m_q[0] | z_m_q[3])) begin
          if (&z_m_q[26:3]) begin
            z_m_d = {1'b1, 26'd0};
            z_e_d = z_e_q + 10'sd1;
          end else begin
            z_m_d = {z_m_q[26:3] + 24'd1, 3'b000};
          end
        end
        state_d = PACK;
      end
      PACK: begin
        if (zero_q) begin
          z_d = 32'h00000000;
        end else if (z_e_q > 10'sd127) begin
          z_d = {z_s_q, 8'hFF, 23'd0};
        end else if ((z_e_q < -10'sd126) || !z_m_q[26]) begin
          z_d = {z_s_q, 31'd0};
        end else begin
          z_d = {z_s_q, 8'(z_e_q + 10'sd127), z_m_q[25:3]};
        end
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (z_stb_q && output_z_ack) begin
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase

    a_ack_d = (state_d == GET_A);
    b_ack_d = (state_d == GET_B);
    z_stb_d = (state_d == PUT_Z);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      k_q     <= '0;
      a_m_q   <= '0;
      b_m_q   <= '0;
      z_m_q   <= '0;
      a_e_q   <= '0;
      b_e_q   <= '0;
      z_e_q   <= '0;
      sum_q   <= '0;
      z_s_q   <= 1'b0;
      zero_q  <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      k_q     <= k_d;
      a_m_q   <= a_m_d;
      b_m_q   <= b_m_d;
      z_m_q   <= z_m_d;
      a_e_q   <= a_e_d;
      b_e_q   <= b_e_d;
      z_e_q   <= z_e_d;
      sum_q   <= sum_d;
      z_s_q   <= z_s_d;
      zero_q  <= zero_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
    end
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z_stb = z_stb_q;
  assign output_z     = z_q;

endmodule

// File: tb/tb_apx_float_addsub.sv
// Directed-vector bench for apx_float_addsub: exact and truncated arithmetic,
// special values, back-pressure and asynchronous reset during alignment.
module tb_apx_float_addsub;

  logic        clk;
  logic        rst;
  logic [31:0] inputA;
  logic        inputAStb;
  logic        inputAAck;
  logic [31:0] inputB;
  logic        inputBStb;
  logic        inputBAck;
  logic        opSel;
  logic [3:0]  apxLevel;
  logic [31:0] outputZ;
  logic        outputZStb;
  logic        outputZAck;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  apx_float_addsub #(.TRUNC_MAX(3), .LVL_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (inputA),
    .input_a_stb  (inputAStb),
    .input_a_ack  (inputAAck),
    .input_b      (inputB),
    .input_b_stb  (inputBStb),
    .input_b_ack  (inputBAck),
    .op           (opSel),
    .apx_level    (apxLevel),
    .output_z     (outputZ),
    .output_z_stb (outputZStb),
    .output_z_ack (outputZAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sendOperands(input logic [31:0] a, input logic [31:0] b,
                              input logic opv, input logic [3:0] lvl);
    int n;
    @(negedge clk);
    n = 0;
    while (!inputAAck && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("a_ack_timeout", 32'(inputAAck), 32'd1);
    inputA    = a;
    inputAStb = 1'b1;
    @(posedge clk);
    #1 inputAStb = 1'b0;
    inputA = 32'hDEADBEEF;
    @(negedge clk);
    n = 0;
    while (!inputBAck && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b_ack_timeout", 32'(inputBAck), 32'd1);
    inputB    = b;
    opSel     = opv;
    apxLevel  = lvl;
    inputBStb = 1'b1;
    @(posedge clk);
    #1 inputBStb = 1'b0;
    inputB   = 32'hDEADBEEF;
    opSel    = ~opv;
    apxLevel = ~lvl;
  endtask

  task automatic waitResult(output logic [31:0] z, output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!outputZStb && n < 60);
    checkOutput("z_stb_timeout", 32'(outputZStb), 32'd1);
    z   = outputZ;
    lat = n - 1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic opv, input logic [3:0] lvl,
                               output logic [31:0] z, output int lat);
    sendOperands(a, b, opv, lvl);
    waitResult(z, lat);
  endtask

  task automatic takeOutput();
    @(negedge clk);
    outputZAck = 1'b1;
    @(posedge clk);
    #1 outputZAck = 1'b0;
  endtask

  logic [31:0] z;
  int          lat;

  initial begin
    rst        = 1'b0;
    inputA     = '0;
    inputAStb  = 1'b0;
    inputB     = '0;
    inputBStb  = 1'b0;
    opSel      = 1'b0;
    apxLevel   = '0;
    outputZAck = 1'b0;
    $display("[TB] start");

    // Reset state and first ack after release.
    repeat (3) @(negedge clk);
    checkOutput("rst_a_ack", 32'(inputAAck), 32'd0);
    checkOutput("rst_b_ack", 32'(inputBAck), 32'd0);
    checkOutput("rst_z_stb", 32'(outputZStb), 32'd0);
    checkOutput("rst_z", outputZ, 32'h00000000);
    rst = 1'b1;
    @(posedge clk);
    #1 checkOutput("rel_a_ack", 32'(inputAAck), 32'd1);

    // Exact add and subtract.
    applyStimulus(32'h3FC00000, 32'h40100000, 1'b0, 4'd0, z, lat);
    checkOutput("add_exact", z, 32'h40700000);
    checkOutput("add_lat", 32'(lat <= 36), 32'd1);
    takeOutput();
    applyStimulus(32'h40800000, 32'h3F800000, 1'b1, 4'd0, z, lat);
    checkOutput("sub_exact", z, 32'h40400000);
    takeOutput();

    // Approximation levels.
    applyStimulus(32'h3F800007, 32'h3F800000, 1'b0, 4'd0, z, lat);
    checkOutput("apx_k0", z, 32'h40000004);
    takeOutput();
    applyStimulus(32'h3F800007, 32'h3F800000, 1'b0, 4'd3, z, lat);
    checkOutput("apx_k3", z, 32'h40000000);
    takeOutput();
    applyStimulus(32'h3F800007, 32'h3F800000, 1'b0, 4'd15, z, lat);
    checkOutput("apx_clamp", z, 32'h40000000);
    takeOutput();

    // Special values.
    applyStimulus(32'h7F800000, 32'hFF800000, 1'b0, 4'd0, z, lat);
    checkOutput("inf_minus_inf", z, 32'h7FC00000);
    checkOutput("special_lat", 32'(lat <= 5), 32'd1);
    takeOutput();
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd0, z, lat);
    checkOutput("overflow", z, 32'h7F800000);
    takeOutput();
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 4'd0, z, lat);
    checkOutput("neg_zeros", z, 32'h80000000);
    takeOutput();
    applyStimulus(32'h7F800001, 32'h3F800000, 1'b0, 4'd0, z, lat);
    checkOutput("nan_in", z, 32'h7FC00000);
    takeOutput();
    applyStimulus(32'hFF800000, 32'h3F800000, 1'b0, 4'd0, z, lat);
    checkOutput("inf_finite", z, 32'hFF800000);
    takeOutput();
    applyStimulus(32'h00000001, 32'h00000001, 1'b0, 4'd0, z, lat);
    checkOutput("denorm_flush", z, 32'h00000000);
    takeOutput();

    // Exact cancellation, underflow and saturated alignment.
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 4'd0, z, lat);
    checkOutput("cancel_zero", z, 32'h00000000);
    takeOutput();
    applyStimulus(32'h00800000, 32'h00800001, 1'b1, 4'd0, z, lat);
    checkOutput("underflow", z, 32'h80000000);
    takeOutput();
    applyStimulus(32'h4D000000, 32'h3F800000, 1'b0, 4'd0, z, lat);
    checkOutput("far_add", z, 32'h4D000000);
    takeOutput();
    applyStimulus(32'h4D000000, 32'h3F800000, 1'b1, 4'd0, z, lat);
    checkOutput("far_sub_rne", z, 32'h4D000000);
    takeOutput();
    applyStimulus(32'h4D000000, 32'h3F800000, 1'b1, 4'd3, z, lat);
    checkOutput("far_sub_trunc", z, 32'h4CFFFFFF);
    takeOutput();
    applyStimulus(32'h3F800000, 32'h00800000, 1'b0, 4'd0, z, lat);
    checkOutput("max_align", z, 32'h3F800000);
    checkOutput("max_align_lat", 32'(lat <= 36), 32'd1);
    takeOutput();

    // Back-pressure: result and handshake must hold while unacknowledged.
    applyStimulus(32'h3FC00000, 32'h40100000, 1'b0, 4'd0, z, lat);
    checkOutput("bp_first", z, 32'h40700000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp_stb", 32'(outputZStb), 32'd1);
      checkOutput("bp_z", outputZ, 32'h40700000);
      checkOutput("bp_a_ack", 32'(inputAAck), 32'd0);
    end
    @(negedge clk);
    outputZAck = 1'b1;
    @(posedge clk);
    #1 outputZAck = 1'b0;
    checkOutput("bp_release_a_ack", 32'(inputAAck), 32'd1);
    checkOutput("bp_release_stb", 32'(outputZStb), 32'd0);

    // Asynchronous reset while aligning a 23-bit exponent gap.
    sendOperands(32'h4B000000, 32'h3F800000, 1'b0, 4'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_a_ack", 32'(inputAAck), 32'd0);
    checkOutput("mid_rst_b_ack", 32'(inputBAck), 32'd0);
    checkOutput("mid_rst_z_stb", 32'(outputZStb), 32'd0);
    checkOutput("mid_rst_z", outputZ, 32'h00000000);
    repeat (2) @(negedge clk);
    checkOutput("mid_rst_hold_stb", 32'(outputZStb), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 checkOutput("mid_rel_a_ack", 32'(inputAAck), 32'd1);
    applyStimulus(32'h3FC00000, 32'h40100000, 1'b0, 4'd0, z, lat);
    checkOutput("post_rst_add", z, 32'h40700000);
    takeOutput();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
